// File: rtl/dpot_sweep.sv
// Wiper sweep sequencer for the Pmod DPOT SPI writer: steps start_val -> end_val,
// one handshaked 8-bit write per point, optional dwell and triangle bounce.
module dpot_sweep #(
   parameter int DWELL_W = 16
) (
   input  logic               SCLK,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               triangle,
   input  logic [7:0]         start_val,
   input  logic [7:0]         end_val,
   input  logic [7:0]         step,
   input  logic [DWELL_W-1:0] dwell,
   output logic [7:0]         dpot_value,
   output logic               dpot_update,
   input  logic               dpot_ready,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, REQ, XFER, DWELL} state_t;

   typedef struct packed {
      logic [7:0]         sv;
      logic [7:0]         ev;
      logic [7:0]         stp;
      logic               bounce;
      logic [DWELL_W-1:0] dw;
   } cfg_t;

   state_t             state;
   cfg_t               cfg;
   logic [7:0]         cur, tgt;
   logic               stop_l;
   logic [DWELL_W-1:0] cnt;

   logic       halt, at_end, fin, adv;
   logic [7:0] nxt_tgt, nxt_cur;

   // Move c one step toward t; 9-bit math so the result clamps at t instead of wrapping.
   function automatic logic [7:0] step_to(input logic [7:0] c, input logic [7:0] t,
                                          input logic [7:0] s);
      logic [8:0] sum, diff;
      sum  = {1'b0, c} + {1'b0, s};
      diff = {1'b0, c} - {1'b0, s};
      if (t >= c) return (sum > {1'b0, t}) ? t : sum[7:0];
      else        return (diff[8] || diff[7:0] < t) ? t : diff[7:0];
   endfunction

   always_comb begin
      halt    = stop_l | stop;
      at_end  = (cur == tgt);
      nxt_tgt = tgt;
      if (at_end) nxt_tgt = (tgt == cfg.ev) ? cfg.sv : cfg.ev;
      nxt_cur = step_to(cur, nxt_tgt, cfg.stp);
      fin     = halt | (at_end & ~cfg.bounce);
      adv     = ((state == XFER) && dpot_ready && (cfg.dw == '0)) ||
                ((state == DWELL) && (cnt <= DWELL_W'(1)));
   end

   always_ff @(posedge SCLK or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cfg         <= '0;
         cur         <= '0;
         tgt         <= '0;
         stop_l      <= 1'b0;
         cnt         <= '0;
         dpot_value  <= '0;
         dpot_update <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state != IDLE && stop) stop_l <= 1'b1;
         case (state)
            IDLE: begin
               stop_l <= start & stop;
               if (start) begin
                  cfg         <= '{sv: start_val, ev: end_val,
                                   stp: (step == 8'd0) ? 8'd1 : step,
                                   bounce: triangle, dw: dwell};
                  cur         <= start_val;
                  tgt         <= end_val;
                  dpot_value  <= start_val;
                  dpot_update <= 1'b1;
                  busy        <= 1'b1;
                  state       <= REQ;
               end
            end
            REQ: if (!dpot_ready) begin
               dpot_update <= 1'b0;
               state       <= XFER;
            end
            XFER: if (dpot_ready && cfg.dw != '0) begin
               cnt   <= cfg.dw;
               state <= DWELL;
            end
            DWELL: if (cnt > DWELL_W'(1)) cnt <= cnt - DWELL_W'(1);
            default: state <= IDLE;
         endcase
         // Write boundary: either finish or launch the next point.
         if (adv) begin
            if (fin) begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               cur         <= nxt_cur;
               tgt         <= nxt_tgt;
               dpot_value  <= nxt_cur;
               dpot_update <= 1'b1;
               state       <= REQ;
            end
         end
      end
   end

endmodule

// File: tb/tb_dpot_sweep.sv
// Bench for dpot_sweep: randomized writer model, table-driven sweeps, reset/stop corner sequences.
module tb_dpot_sweep;

   logic        SCLK = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0, triangle = 1'b0;
   logic [7:0]  start_val = '0, end_val = '0, step = '0;
   logic [15:0] dwell = '0;
   logic [7:0]  dpot_value;
   logic        dpot_update, busy, done;
   logic        dpot_ready = 1'b1;

   dpot_sweep #(.DWELL_W(16)) dut (
      .SCLK(SCLK), .rst(rst), .start(start), .stop(stop), .triangle(triangle),
      .start_val(start_val), .end_val(end_val), .step(step), .dwell(dwell),
      .dpot_value(dpot_value), .dpot_update(dpot_update), .dpot_ready(dpot_ready),
      .busy(busy), .done(done)
   );

   always #5 SCLK = ~SCLK;

   int n_chk = 0, n_fail = 0;
   int wr_q[$];
   int exp_q[$];
   int done_cnt = 0;
   int cyc = 0, rise_cyc = 0, cur_dwell = 0;
   bit first_wr = 1'b1;
   bit prev_busy = 1'b0;
   int w_st = 0, w_cnt = 0;
   logic [7:0] w_val = '0;

   task automatic chk(input string name, input bit ok, input int act, input int exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Writer model: accepts update after 1..20 cycles, busy (ready low) 2..7 cycles.
   always @(negedge SCLK) begin
      cyc++;
      if (rst) begin
         w_st = 0;
         dpot_ready = 1'b1;
      end else begin
         case (w_st)
            0: if (dpot_update) begin
               if (!first_wr) chk("dwell_gap", (cyc - rise_cyc) >= cur_dwell + 1,
                                  cyc - rise_cyc, cur_dwell + 1);
               first_wr = 1'b0;
               w_val = dpot_value;
               w_cnt = $urandom_range(0, 19);
               w_st  = 1;
            end
            1: begin
               chk("upd_held", dpot_update == 1'b1, dpot_update, 1);
               chk("val_stable_req", dpot_value == w_val, dpot_value, w_val);
               if (w_cnt == 0) begin
                  dpot_ready = 1'b0;
                  wr_q.push_back(int'(w_val));
                  w_cnt = $urandom_range(1, 6);
                  w_st  = 2;
               end else w_cnt--;
            end
            default: begin
               chk("upd_low_xfer", dpot_update == 1'b0, dpot_update, 0);
               chk("val_stable_xfer", dpot_value == w_val, dpot_value, w_val);
               if (w_cnt == 0) begin
                  dpot_ready = 1'b1;
                  rise_cyc = cyc;
                  w_st = 0;
               end else w_cnt--;
            end
         endcase
      end
   end

   always @(negedge SCLK) begin
      if (!rst && done) begin
         done_cnt++;
         chk("done_on_busy_fall", prev_busy && !busy, {prev_busy, busy}, 2);
      end
      prev_busy = busy;
   end

   // Reference: list of wiper codes the sweep should emit, up to maxn writes.
   function automatic void model(input int s, input int e, input int st, input bit bounce,
                                 input int maxn);
      int stp, c, t;
      stp = (st == 0) ? 1 : st;
      c = s;
      t = e;
      exp_q.delete();
      exp_q.push_back(c);
      while (exp_q.size() < maxn) begin
         if (c == t) begin
            if (!bounce) break;
            t = (t == e) ? s : e;
         end
         if (c < t)      c = (c + stp > t) ? t : c + stp;
         else if (c > t) c = (c - stp < t) ? t : c - stp;
         exp_q.push_back(c);
      end
   endfunction

   task automatic cmp_list(input string name);
      chk({name, "_count"}, wr_q.size() == exp_q.size(), wr_q.size(), exp_q.size());
      for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
         chk({name, "_val"}, wr_q[i] == exp_q[i], wr_q[i], exp_q[i]);
   endtask

   task automatic run(input logic [7:0] s, input logic [7:0] e, input logic [7:0] st,
                      input logic [15:0] d, input bit bounce, input int stop_after,
                      input bit same, input bit poke, input string name);
      bit stopped, poked;
      wr_q.delete();
      first_wr  = 1'b1;
      cur_dwell = int'(d);
      done_cnt  = 0;
      stopped   = 1'b0;
      poked     = 1'b0;
      @(negedge SCLK);
      start_val = s; end_val = e; step = st; dwell = d; triangle = bounce;
      start = 1'b1; stop = same;
      @(negedge SCLK);
      start = 1'b0; stop = 1'b0;
      // Scramble the live inputs; the sweep must run on its captured copy.
      start_val = 8'($urandom); end_val = 8'($urandom); step = 8'($urandom);
      dwell = 16'($urandom_range(0, 9)); triangle = ~bounce;
      for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
         @(negedge SCLK);
         start = 1'b0; stop = 1'b0;
         if (!stopped && stop_after != 0 && wr_q.size() >= stop_after) begin
            stop = 1'b1; stopped = 1'b1;
         end
         if (poke && !poked && wr_q.size() == 2) begin
            start = 1'b1; start_val = 8'hAA; poked = 1'b1;
         end
      end
      start = 1'b0; stop = 1'b0;
      chk({name, "_done_seen"}, done_cnt != 0, done_cnt, 1);
      repeat (4) @(negedge SCLK);
      chk({name, "_busy_after"}, busy == 1'b0, busy, 0);
      chk({name, "_done_once"}, done_cnt == 1, done_cnt, 1);
      model(int'(s), int'(e), int'(st), bounce, same ? 1 : (stop_after != 0 ? stop_after : 1000));
      cmp_list(name);
   endtask

   typedef struct {
      logic [7:0]  s, e, st;
      logic [15:0] d;
      bit          bounce;
      int          stop_after;
      bit          same, poke;
      int          exp_n;
      logic [7:0]  exp_last;
   } vec_t;

   vec_t vt[8];

   initial begin
      vt[0] = '{8'h10, 8'h40, 8'h10, 16'd0, 1'b0, 0, 1'b0, 1'b1, 4, 8'h40};
      vt[1] = '{8'hF0, 8'h05, 8'h20, 16'd3, 1'b0, 0, 1'b0, 1'b0, 9, 8'h05};
      vt[2] = '{8'h00, 8'h03, 8'h01, 16'd0, 1'b1, 8, 1'b0, 1'b0, 8, 8'h01};
      vt[3] = '{8'h55, 8'h99, 8'h01, 16'd0, 1'b0, 0, 1'b1, 1'b0, 1, 8'h55};
      vt[4] = '{8'h03, 8'h07, 8'h00, 16'd2, 1'b0, 0, 1'b0, 1'b0, 5, 8'h07};
      vt[5] = '{8'h77, 8'h77, 8'h05, 16'd1, 1'b1, 3, 1'b0, 1'b0, 3, 8'h77};
      vt[6] = '{8'h02, 8'h00, 8'hFF, 16'd0, 1'b0, 0, 1'b0, 1'b0, 2, 8'h00};
      vt[7] = '{8'hF0, 8'hFF, 8'h20, 16'd1, 1'b0, 0, 1'b0, 1'b0, 2, 8'hFF};

      repeat (3) @(negedge SCLK);
      chk("rst_value", dpot_value == 8'h00, dpot_value, 0);
      chk("rst_update", dpot_update == 1'b0, dpot_update, 0);
      chk("rst_busy", busy == 1'b0, busy, 0);
      chk("rst_done", done == 1'b0, done, 0);
      rst = 1'b0;
      repeat (2) @(negedge SCLK);

      // A stop pulse in IDLE must not leak into the next sweep.
      stop = 1'b1;
      @(negedge SCLK);
      stop = 1'b0;
      chk("idle_stop_busy", busy == 1'b0, busy, 0);

      for (int i = 0; i < 8; i++) begin
         run(vt[i].s, vt[i].e, vt[i].st, vt[i].d, vt[i].bounce, vt[i].stop_after,
             vt[i].same, vt[i].poke, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_n", i), wr_q.size() == vt[i].exp_n, wr_q.size(), vt[i].exp_n);
         if (wr_q.size() != 0)
            chk($sformatf("vec%0d_last", i), wr_q[$] == int'(vt[i].exp_last),
                wr_q[$], vt[i].exp_last);
      end

      for (int i = 0; i < 8; i++) begin
         logic [7:0]  rs, re, rst_step;
         logic [15:0] rd;
         bit          rb;
         int          sa;
         rs = 8'($urandom); re = 8'($urandom);
         rst_step = 8'($urandom_range(3, 48));
         rd = 16'($urandom_range(0, 4));
         rb = 1'($urandom_range(0, 1));
         sa = rb ? int'($urandom_range(1, 12))
                 : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
         run(rs, re, rst_step, rd, rb, sa, 1'b0, 1'b0, $sformatf("rnd%0d", i));
      end

      // Reset in the middle of a transfer.
      @(negedge SCLK);
      start_val = 8'h20; end_val = 8'hE0; step = 8'h10; dwell = 16'd0; triangle = 1'b0;
      start = 1'b1;
      @(negedge SCLK);
      start = 1'b0;
      begin
         bit seen;
         seen = 1'b0;
         for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge SCLK);
            seen = (w_st == 2) && !dpot_update && (wr_q.size() >= 3);
         end
         chk("xfer_reached", seen, seen, 1);
      end
      #2 rst = 1'b1;
      #1;
      chk("async_rst_update", dpot_update == 1'b0, dpot_update, 0);
      chk("async_rst_value", dpot_value == 8'h00, dpot_value, 0);
      chk("async_rst_busy", busy == 1'b0, busy, 0);
      repeat (2) @(negedge SCLK);
      rst = 1'b0;
      run(8'h10, 8'h40, 8'h10, 16'd0, 1'b0, 0, 1'b0, 1'b0, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
